// File: rtl/ripple_carry_adder_unit.sv
// ripple_carry_adder_unit
// Registered WIDTH-bit ripple-carry adder built from a chain of one-bit
// full-adder cells. Produces sum, carry out, signed overflow and a zero flag
// one cycle after an in_valid capture. When in_valid is low, the result
// registers hold their previous values.
module ripple_carry_adder_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  // One-bit full-adder sum output.
  function automatic logic fa_sum(input logic fa_a, input logic fa_b, input logic fa_c);
    return fa_a ^ fa_b ^ fa_c;
  endfunction

  // One-bit full-adder carry output: majority of the three inputs.
  function automatic logic fa_carry(input logic fa_a, input logic fa_b, input logic fa_c);
    return (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
  endfunction

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;
  logic             w_zero;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;
  logic             r_valid;

  assign w_carry[0] = cin;

  // The carry ripples cell by cell from bit 0 upward; no lookahead.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign w_sum[gi]       = fa_sum(a[gi], b[gi], w_carry[gi]);
    assign w_carry[gi + 1] = fa_carry(a[gi], b[gi], w_carry[gi]);
  end

  // Signed overflow: the carry into the sign bit differs from the carry out of it.
  // For WIDTH = 1 w_carry[0] is cin, so this becomes cout XOR cin.
  assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  // Zero looks only at the sum bits; the carry out is deliberately ignored.
  assign w_zero = (w_sum == {WIDTH{1'b0}});

  // Capture a new result when in_valid is high, otherwise hold; out_valid pulses per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum      <= {WIDTH{1'b0}};
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum      <= w_sum;
        r_cout     <= w_carry[WIDTH];
        r_overflow <= w_overflow;
        r_zero     <= w_zero;
      end else begin
        r_sum      <= r_sum;
        r_cout     <= r_cout;
        r_overflow <= r_overflow;
        r_zero     <= r_zero;
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_ripple_carry_adder_unit.sv
// Self-checking bench for ripple_carry_adder_unit at WIDTH = 4.
// The reference model uses plain integer arithmetic: the unsigned sum for
// {cout, sum} and a signed range check for overflow.
module tb_ripple_carry_adder_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       overflow;
  logic       zero;
  logic       out_valid;

  int checks;
  int failures;

  // Expected {zero, overflow, cout, sum} currently held by the DUT.
  logic [6:0] held_exp;
  logic       prev_valid;

  ripple_carry_adder_unit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {zero, overflow, cout, sum}.
  function automatic logic [6:0] ref_model(input logic [3:0] fa, input logic [3:0] fb, input logic fc);
    int         u;
    int         s;
    logic [4:0] u5;
    logic       ovf;
    u   = int'(fa) + int'(fb) + int'(fc);
    s   = int'($signed(fa)) + int'($signed(fb)) + int'(fc);
    ovf = (s > 7) || (s < -8);
    u5  = u[4:0];
    return {(u5[3:0] == 4'd0), ovf, u5[4], u5[3:0]};
  endfunction

  task automatic test_reset();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a = 4'd0; b = 4'd0; cin = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({zero, overflow, cout, sum, out_valid} !== 8'd0) begin
      failures++;
      $display("FAIL reset_async: got %b expected %b", {zero, overflow, cout, sum, out_valid}, 8'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({zero, overflow, cout, sum, out_valid} !== 8'd0) begin
      failures++;
      $display("FAIL reset_held: got %b expected %b", {zero, overflow, cout, sum, out_valid}, 8'd0);
    end
    rst_n      = 1'b1;
    held_exp   = 7'd0;
    prev_valid = 1'b0;
  endtask

  // Spec vectors back to back, then one idle cycle with garbage inputs.
  task automatic test_vectors();
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic       vc [4];
    logic [6:0] ve [4];
    va[0] = 4'b0001; vb[0] = 4'b0010; vc[0] = 1'b0; ve[0] = 7'b0_0_0_0011;
    va[1] = 4'b0101; vb[1] = 4'b0011; vc[1] = 1'b0; ve[1] = 7'b0_1_0_1000;
    va[2] = 4'b1111; vb[2] = 4'b0001; vc[2] = 1'b0; ve[2] = 7'b1_0_1_0000;
    va[3] = 4'b1111; vb[3] = 4'b1111; vc[3] = 1'b1; ve[3] = 7'b0_0_1_1111;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) begin
        checks++;
        if (out_valid !== (k <= 4)) begin
          failures++;
          $display("FAIL vec_valid[%0d]: got %b expected %b", k, out_valid, (k <= 4));
        end
        checks++;
        if ({zero, overflow, cout, sum} !== ve[(k <= 4) ? k - 1 : 3]) begin
          failures++;
          $display("FAIL vec_result[%0d]: got %b expected %b", k, {zero, overflow, cout, sum}, ve[(k <= 4) ? k - 1 : 3]);
        end
      end
      if (k < 4) begin
        in_valid = 1'b1; a = va[k]; b = vb[k]; cin = vc[k];
      end else begin
        in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
    end
    held_exp   = ve[3];
    prev_valid = 1'b0;
  endtask

  // Outputs hold 1111/cout=1; reset mid-cycle must clear them with no clock edge.
  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({zero, overflow, cout, sum, out_valid} !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: got %b expected %b", {zero, overflow, cout, sum, out_valid}, 8'd0);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    held_exp   = 7'd0;
    prev_valid = 1'b0;
  endtask

  // An operation presented while reset is asserted must leave no trace.
  task automatic test_reset_mid_op();
    in_valid = 1'b1; a = 4'd3; b = 4'd4; cin = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checks++;
    if ({zero, overflow, cout, sum, out_valid} !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_op: got %b expected %b", {zero, overflow, cout, sum, out_valid}, 8'd0);
    end
    // First capture after release: result exactly one cycle later.
    in_valid = 1'b1; a = 4'd6; b = 4'd1; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, zero, overflow, cout, sum} !== {1'b1, 7'b0_0_0_0111}) begin
      failures++;
      $display("FAIL release_capture: got %b expected %b", {out_valid, zero, overflow, cout, sum}, {1'b1, 7'b0_0_0_0111});
    end
    held_exp   = 7'b0_0_0_0111;
    prev_valid = 1'b0;
    @(negedge clk);
  endtask

  // All 512 operand combinations streamed back to back.
  task automatic test_exhaustive();
    logic [8:0] v;
    for (int k = 0; k <= 512; k++) begin
      checks++;
      if ({out_valid, zero, overflow, cout, sum} !== {prev_valid, held_exp}) begin
        failures++;
        $display("FAIL exhaustive[%0d]: got %b expected %b", k, {out_valid, zero, overflow, cout, sum}, {prev_valid, held_exp});
      end
      if (k < 512) begin
        v = 9'(k);
        in_valid = 1'b1; a = v[3:0]; b = v[7:4]; cin = v[8];
        held_exp = ref_model(a, b, cin);
      end else begin
        in_valid = 1'b0;
      end
      prev_valid = in_valid;
      @(negedge clk);
    end
  endtask

  // Random operands with random idle gaps; idle cycles carry random garbage.
  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      checks++;
      if ({out_valid, zero, overflow, cout, sum} !== {prev_valid, held_exp}) begin
        failures++;
        $display("FAIL random[%0d]: got %b expected %b", k, {out_valid, zero, overflow, cout, sum}, {prev_valid, held_exp});
      end
      in_valid = ($urandom_range(0, 3) != 0);
      a   = 4'($urandom);
      b   = 4'($urandom);
      cin = 1'($urandom);
      if (in_valid) held_exp = ref_model(a, b, cin);
      prev_valid = in_valid;
      @(negedge clk);
    end
    checks++;
    if ({out_valid, zero, overflow, cout, sum} !== {prev_valid, held_exp}) begin
      failures++;
      $display("FAIL random_last: got %b expected %b", {out_valid, zero, overflow, cout, sum}, {prev_valid, held_exp});
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    held_exp   = 7'd0;
    prev_valid = 1'b0;
    test_reset();
    @(negedge clk);
    test_vectors();
    test_async_reset();
    test_reset_mid_op();
    test_exhaustive();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
